// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle word format, reference angles in 16.4 degrees,
// and the angle-reduction controller state encoding.
package cordic_pkg;

    localparam int ANGLE_W    = 20;
    localparam int ANGLE_FRAC = 4;

    localparam int DEG_90  = 90  << ANGLE_FRAC;
    localparam int DEG_180 = 180 << ANGLE_FRAC;
    localparam int DEG_360 = 360 << ANGLE_FRAC;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_FOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_angle_reduce.sv
// Reduces an arbitrary 16.4-degree angle into [-90, +90] for the CORDIC core,
// flagging when the downstream sin/cos must be negated to compensate for the fold.
module cordic_angle_reduce
    import cordic_pkg::*;
#(
    parameter int W    = ANGLE_W,
    parameter int FRAC = ANGLE_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] angle_in,
    output logic signed [W-1:0] out_angle,
    output logic                out_negate,
    output logic                out_valid
);

    // Package constants are in ANGLE_FRAC units; rescale to this instance's FRAC.
    localparam logic signed [W-1:0] L_90   = W'((DEG_90  << FRAC) >> ANGLE_FRAC);
    localparam logic signed [W-1:0] L_180  = W'((DEG_180 << FRAC) >> ANGLE_FRAC);
    localparam logic signed [W-1:0] L_360  = W'((DEG_360 << FRAC) >> ANGLE_FRAC);
    localparam logic signed [W-1:0] L_M90  = -L_90;
    localparam logic signed [W-1:0] L_M180 = -L_180;

    state_t              r_state;
    state_t              w_state_next;
    logic signed [W-1:0] r_acc;
    logic signed [W-1:0] w_acc_next;
    logic signed [W-1:0] r_out_angle;
    logic                r_out_negate;
    logic                r_out_valid;
    logic signed [W-1:0] w_fold_angle;
    logic                w_fold_negate;

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc_next   = angle_in;
                    w_state_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                // One full-turn correction per cycle; result lands in (-180, +180].
                if (r_acc > L_180) begin
                    w_acc_next = r_acc - L_360;
                end else if (r_acc <= L_M180) begin
                    w_acc_next = r_acc + L_360;
                end else begin
                    w_state_next = S_FOLD;
                end
            end
            S_FOLD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Rotating by a-180 (or a+180) gives sin/cos of opposite sign, hence negate.
    always_comb begin
        w_fold_angle  = r_acc;
        w_fold_negate = 1'b0;
        if (r_acc > L_90) begin
            w_fold_angle  = r_acc - L_180;
            w_fold_negate = 1'b1;
        end else if (r_acc < L_M90) begin
            w_fold_angle  = r_acc + L_180;
            w_fold_negate = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_out_angle  <= '0;
            r_out_negate <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_out_valid <= (r_state == S_FOLD);
            if (r_state == S_FOLD) begin
                r_out_angle  <= w_fold_angle;
                r_out_negate <= w_fold_negate;
            end
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_angle  = r_out_angle;
    assign out_negate = r_out_negate;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Scoreboard bench for cordic_angle_reduce: directed angles with hand-computed
// reduced angle, negate flag and correction count.
module tb_cordic_angle_reduce;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [19:0] angle_in = '0;
    logic signed [19:0] out_angle;
    logic               out_negate;
    logic               out_valid;

    cordic_angle_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .angle_in   (angle_in),
        .out_angle  (out_angle),
        .out_negate (out_negate),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int angle;
        int neg;
        int acc_edge;
        int k;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_at_edge = 1'b0;
    int last_a = 0;
    int last_n = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge && !out_valid) begin
            chk("hold_angle", int'(out_angle), last_a);
            chk("hold_negate", int'(out_negate), last_n);
        end
        if (out_valid) begin
            chk("ready_with_valid", int'(in_ready), 1);
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_angle", int'(out_angle), e.angle);
                chk("out_negate", int'(out_negate), e.neg);
                chk("latency", cyc - e.acc_edge, e.k + 2);
            end
        end
        last_a = int'(out_angle);
        last_n = int'(out_negate);
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input int a, input int ea, input int en, input int k);
        exp_t e;
        wait_ready();
        angle_in = 20'(a);
        in_valid = 1'b1;
        e.angle = ea; e.neg = en; e.acc_edge = cyc + 1; e.k = k;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stream with in_valid held high: angle, hand-expected acceptance, result, corrections.
    int s_ang [17] = '{32767, 100, 200, 300, 400, 500, 600, 700, 800,
                       -2160, 900, 1000, 3000, 1100, 1200, 1300, -3000};
    int s_rdy [17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    int s_ea  [17] = '{1087, 0, 0, 0, 0, 0, 0, 0, 0, 720, 0, 0, 120, 0, 0, 0, -120};
    int s_en  [17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    int s_k   [17] = '{6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_angle", int'(out_angle), 0);
        chk("rst_out_negate", int'(out_negate), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        @(posedge clk); #1;

        send(720,    720,   0, 0);
        send(2160,   -720,  1, 0);
        send(-2160,  720,   1, 0);
        send(32767,  1087,  1, 6);
        send(-32768, -1088, 1, 6);
        send(2880,   0,     1, 0);
        send(-2880,  0,     1, 1);
        send(1440,   1440,  0, 0);
        send(-1440,  -1440, 0, 0);
        send(0,      0,     0, 0);
        send(5000,   -760,  0, 1);
        send(3000,   120,   1, 1);
        send(1441,   -1439, 1, 0);
        send(-1441,  1439,  1, 0);
        send(2881,   1,     1, 1);
        drain();

        wait_ready();
        for (int i = 0; i < 17; i++) begin
            angle_in = 20'(s_ang[i]);
            in_valid = 1'b1;
            chk("stream_in_ready", int'(in_ready), s_rdy[i]);
            if (s_rdy[i] != 0) begin
                e.angle = s_ea[i]; e.neg = s_en[i]; e.acc_edge = cyc + 1; e.k = s_k[i];
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        wait_ready();
        angle_in = 20'(32767);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_angle", int'(out_angle), 0);
        chk("abort_out_negate", int'(out_negate), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_out_angle_later", int'(out_angle), 0);
        send(720, 720, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
